uart_rx_axis: RTL

Parametrised UART receiver, next generation of the team's fixed 8-bit receiver. Run-time bit divisor, parity mode and stop-bit count; DATA_WIDTH from 5 to 9. Glitch-filtered start detection and per-frame error tagging. Output is a one-entry AXI-Stream master with overrun reporting, feeding the UART subsystem's RX FIFO.

---
 rtl/uart_pkg.sv | 29 ++
 rtl/uart_rx_sampler.sv | 73 +++++++
 rtl/uart_rx_axis.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the UART receive path.
// Holds parity mode / FSM state enums and the tuser bit positions.
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE  = 2'b00,
    PAR_EVEN  = 2'b01,
    PAR_ODD   = 2'b10,
    PAR_NONE3 = 2'b11
  } parity_mode_e;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP1,
    STOP2
  } rx_state_e;

  localparam int TUSER_PAR = 0;
  localparam int TUSER_FRM = 1;
  localparam int TUSER_BRK = 2;

  function automatic logic par_on(parity_mode_e m);
    return (m == PAR_EVEN) || (m == PAR_ODD);
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler: rx synchroniser, bit-period counter and bit decision.
// Ports: clk_i, rst_i, rx_i, run_i, start_i, div_i in; rx_o, fall_o,
// dec_stb_o, dec_val_o, end_o out. UART_RX_MAJORITY_EN: 3-sample vote.
module uart_rx_sampler #(
  parameter int DIV_WIDTH = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 rx_i,
  input  logic                 run_i,
  input  logic                 start_i,
  input  logic [DIV_WIDTH-1:0] div_i,
  output logic                 rx_o,
  output logic                 fall_o,
  output logic                 dec_stb_o,
  output logic                 dec_val_o,
  output logic                 end_o
);

  localparam logic [DIV_WIDTH-1:0] ONE = DIV_WIDTH'(1);

  logic                 s1_q, s2_q, prev_q;
  logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
  logic [DIV_WIDTH-1:0] half;

  assign half   = div_i >> 1;
  assign rx_o   = s2_q;
  assign fall_o = prev_q & ~s2_q;
  assign end_o  = run_i && (cnt_q == div_i - ONE);

  always_comb begin
    cnt_d = '0;
    if (start_i)    cnt_d = '0;
    else if (end_o) cnt_d = '0;
    else if (run_i) cnt_d = cnt_q + ONE;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_q   <= 1'b1;
      s2_q   <= 1'b1;
      prev_q <= 1'b1;
      cnt_q  <= '0;
    end else begin
      s1_q   <= rx_i;
      s2_q   <= s1_q;
      prev_q <= s2_q;
      cnt_q  <= cnt_d;
    end
  end

`ifdef UART_RX_MAJORITY_EN
  logic v0_q, v1_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      v0_q <= 1'b1;
      v1_q <= 1'b1;
    end else begin
      if (cnt_q == half - ONE) v0_q <= s2_q;
      if (cnt_q == half)       v1_q <= s2_q;
    end
  end

  // third vote is the live sample at h+1
  assign dec_stb_o = run_i && (cnt_q == half + ONE);
  assign dec_val_o = (v0_q & v1_q) | (v0_q & s2_q) | (v1_q & s2_q);
`else
  assign dec_stb_o = run_i && (cnt_q == half);
  assign dec_val_o = s2_q;
`endif

endmodule

// File: rtl/uart_rx_axis.sv
// uart_rx_axis: UART receiver with a one-entry AXI-Stream output register.
// Ports: clk_i, rst_i, rx_i, bit_div_i, parity_mode_i, stop2_i, m_axis_*,
// overrun_o, busy_o. UART_RX_MAJORITY_EN selects 3-sample voting.
module uart_rx_axis
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  rx_i,
  input  logic [DIV_WIDTH-1:0]  bit_div_i,
  input  logic [1:0]            parity_mode_i,
  input  logic                  stop2_i,
  output logic [DATA_WIDTH-1:0] m_axis_tdata_o,
  output logic [2:0]            m_axis_tuser_o,
  output logic                  m_axis_tvalid_o,
  input  logic                  m_axis_tready_i,
  output logic                  overrun_o,
  output logic                  busy_o
);

  rx_state_e             state_q;
  logic [DIV_WIDTH-1:0]  div_q;
  logic                  par_en_q, par_odd_q, stop2_q;
  logic [DATA_WIDTH-1:0] sh_q;
  logic [3:0]            idx_q;
  logic                  zero_q, perr_q, ferr_q, brkw_q;
  logic [DATA_WIDTH-1:0] tdata_q;
  logic [2:0]            tuser_q;
  logic                  tvalid_q, ovr_q;

  logic rx_s, fall, dec_stb, dec_val, bit_end, start;
  logic done, brk_now, par_exp;
  logic [2:0] user_d;
  parity_mode_e pm;

  assign pm    = parity_mode_e'(parity_mode_i);
  assign start = (state_q == IDLE) && fall;

  uart_rx_sampler #(.DIV_WIDTH(DIV_WIDTH)) u_smp (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .rx_i      (rx_i),
    .run_i     (state_q != IDLE),
    .start_i   (start),
    .div_i     (div_q),
    .rx_o      (rx_s),
    .fall_o    (fall),
    .dec_stb_o (dec_stb),
    .dec_val_o (dec_val),
    .end_o     (bit_end)
  );

  // completion and tag of the frame ending this cycle
  always_comb begin
    done    = 1'b0;
    brk_now = 1'b0;
    user_d  = '0;
    par_exp = par_odd_q ? ~^sh_q : ^sh_q;
    user_d[TUSER_PAR] = perr_q;
    if (dec_stb && !brkw_q) begin
      if (state_q == STOP1) begin
        if (zero_q && !dec_val) begin
          brk_now = 1'b1;
          done    = 1'b1;
          user_d[TUSER_BRK] = 1'b1;
          user_d[TUSER_FRM] = 1'b1;
        end else if (!stop2_q) begin
          done = 1'b1;
          user_d[TUSER_FRM] = !dec_val;
        end
      end else if (state_q == STOP2) begin
        done = 1'b1;
        user_d[TUSER_FRM] = ferr_q | !dec_val;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      div_q     <= DIV_WIDTH'(4);
      par_en_q  <= 1'b0;
      par_odd_q <= 1'b0;
      stop2_q   <= 1'b0;
      sh_q      <= '0;
      idx_q     <= '0;
      zero_q    <= 1'b1;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
      brkw_q    <= 1'b0;
      tdata_q   <= '0;
      tuser_q   <= '0;
      tvalid_q  <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      ovr_q <= 1'b0;
      if (tvalid_q && m_axis_tready_i) tvalid_q <= 1'b0;
      if (done) begin
        if (!tvalid_q || m_axis_tready_i) begin
          tdata_q  <= sh_q;
          tuser_q  <= user_d;
          tvalid_q <= 1'b1;
        end else begin
          ovr_q <= 1'b1;
        end
      end

      unique case (state_q)
        IDLE: begin
          if (fall) begin
            div_q     <= (bit_div_i < DIV_WIDTH'(4)) ?
                         DIV_WIDTH'(4) : bit_div_i;
            par_en_q  <= par_on(pm);
            par_odd_q <= (pm == PAR_ODD);
            stop2_q   <= stop2_i;
            idx_q     <= '0;
            zero_q    <= 1'b1;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
            brkw_q    <= 1'b0;
            state_q   <= START;
          end
        end
        START: begin
          if (dec_stb && dec_val) state_q <= IDLE;
          else if (bit_end)       state_q <= DATA;
        end
        DATA: begin
          if (dec_stb) begin
            sh_q <= {dec_val, sh_q[DATA_WIDTH-1:1]};
            if (dec_val) zero_q <= 1'b0;
          end
          if (bit_end) begin
            idx_q <= idx_q + 4'd1;
            if (idx_q == 4'(DATA_WIDTH - 1))
              state_q <= par_en_q ? PARITY : STOP1;
          end
        end
        PARITY: begin
          if (dec_stb) begin
            perr_q <= (dec_val != par_exp);
            if (dec_val) zero_q <= 1'b0;
          end
          if (bit_end) state_q <= STOP1;
        end
        STOP1: begin
          if (brkw_q) begin
            // hold off restarting until the break releases
            if (rx_s) state_q <= IDLE;
          end else begin
            if (dec_stb) ferr_q <= !dec_val;
            if (brk_now)      brkw_q  <= 1'b1;
            else if (done)    state_q <= IDLE;
            else if (bit_end) state_q <= STOP2;
          end
        end
        STOP2: begin
          if (done) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign m_axis_tdata_o  = tdata_q;
  assign m_axis_tuser_o  = tuser_q;
  assign m_axis_tvalid_o = tvalid_q;
  assign overrun_o       = ovr_q;
  assign busy_o          = (state_q != IDLE);

endmodule
